// File: rtl/i2c_arbiter_if.sv
// Bundle of requester-side and I2C-master-side signals for the two-port I2C arbiter.
// The slave modport is the arbiter's view; the master modport is the environment driving requests and m_busy.
interface i2c_arbiter_if;
    logic       req0;
    logic       req1;
    logic [2:0] addr0;
    logic [2:0] addr1;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       rw0;
    logic       rw1;

    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic       err;

    logic       m_start;
    logic [2:0] m_addr;
    logic [7:0] m_data;
    logic       m_rw;
    logic       m_busy;

    modport slave (
        input  req0, req1, addr0, addr1, data0, data1, rw0, rw1, m_busy,
        output gnt0, gnt1, done0, done1, err, m_start, m_addr, m_data, m_rw
    );

    modport master (
        output req0, req1, addr0, addr1, data0, data1, rw0, rw1, m_busy,
        input  gnt0, gnt1, done0, done1, err, m_start, m_addr, m_data, m_rw
    );
endinterface

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master between two requesters; issues a one-cycle
// command pulse, waits for the master's busy handshake with bounded timeouts, and reports completion.
module i2c_arbiter #(
    parameter int unsigned BUSY_WAIT = 15,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic         clk,
    input  logic         reset,
    i2c_arbiter_if.slave bus
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    localparam logic [7:0] BUSY_WAIT_LIM = 8'(BUSY_WAIT);
    localparam logic [7:0] TIMEOUT_LIM   = 8'(TIMEOUT);

    logic [2:0] state_q,   state_d;
    logic [7:0] cnt_q,     cnt_d;
    logic [1:0] gnt_q,     gnt_d;
    logic       owner_q,   owner_d;
    logic       last_q,    last_d;
    logic [2:0] m_addr_q,  m_addr_d;
    logic [7:0] m_data_q,  m_data_d;
    logic       m_rw_q,    m_rw_d;
    logic       m_start_q, m_start_d;
    logic [1:0] done_q,    done_d;
    logic       err_q,     err_d;

    logic       winner;
    logic [7:0] cnt_inc;
    logic [1:0] owner_hot;

    // Saturating increment: the counter parks at 255 instead of wrapping back to zero.
    assign cnt_inc   = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
    assign owner_hot = owner_q ? 2'b10 : 2'b01;

    // On a tie the requester that was not served last wins; otherwise the lone requester wins.
    assign winner = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned,
        // which would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        m_addr_d  = m_addr_q;
        m_data_d  = m_data_q;
        m_rw_d    = m_rw_q;
        m_start_d = 1'b0;
        done_d    = 2'b00;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req0 | bus.req1) begin
                    owner_d   = winner;
                    last_d    = winner;
                    gnt_d     = winner ? 2'b10 : 2'b01;
                    m_addr_d  = winner ? bus.addr1 : bus.addr0;
                    m_data_d  = winner ? bus.data1 : bus.data0;
                    m_rw_d    = winner ? bus.rw1   : bus.rw0;
                    m_start_d = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                cnt_d   = 8'd0;
                state_d = ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY: begin
                if (bus.m_busy) begin
                    cnt_d   = 8'd0;
                    state_d = ST_WAIT_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= BUSY_WAIT_LIM) begin
                        err_d   = 1'b1;
                        done_d  = owner_hot;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_WAIT_IDLE: begin
                if (!bus.m_busy) begin
                    done_d  = owner_hot;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= TIMEOUT_LIM) begin
                        err_d   = 1'b1;
                        done_d  = owner_hot;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end

            default: begin
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

    // last_q resets to requester 1 so requester 0 takes the first tie after reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples the
        // pre-edge values regardless of statement order.
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            gnt_q     <= 2'b00;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            m_addr_q  <= 3'd0;
            m_data_q  <= 8'd0;
            m_rw_q    <= 1'b0;
            m_start_q <= 1'b0;
            done_q    <= 2'b00;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            m_addr_q  <= m_addr_d;
            m_data_q  <= m_data_d;
            m_rw_q    <= m_rw_d;
            m_start_q <= m_start_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.gnt0    = gnt_q[0];
    assign bus.gnt1    = gnt_q[1];
    assign bus.done0   = done_q[0];
    assign bus.done1   = done_q[1];
    assign bus.err     = err_q;
    assign bus.m_start = m_start_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_rw    = m_rw_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed self-checking bench for i2c_arbiter: a scoreboard of expected completions is
// filled as requests are driven and drained by a monitor on every done pulse.
module tb_i2c_arbiter;

    localparam int BW = 15;
    localparam int TO = 255;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    i2c_arbiter_if bus ();

    i2c_arbiter #(
        .BUSY_WAIT (BW),
        .TIMEOUT   (TO)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       owner;
        logic [2:0] addr;
        logic [7:0] data;
        logic       rw;
        logic       err;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic        prev_gnt    = 1'b0;
    logic [11:0] prev_fields = 12'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: bus invariants every cycle, scoreboard comparison on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        check("one_gnt",       bus.gnt0 & bus.gnt1, 1'b0);
        check("one_done",      bus.done0 & bus.done1, 1'b0);
        check("done_with_gnt", (bus.done0 & ~bus.gnt0) | (bus.done1 & ~bus.gnt1), 1'b0);
        check("err_only_done", bus.err & ~(bus.done0 | bus.done1), 1'b0);
        check("start_with_gnt", bus.m_start & ~(bus.gnt0 | bus.gnt1), 1'b0);
        if (prev_gnt && (bus.gnt0 | bus.gnt1))
            check("fields_stable", {bus.m_addr, bus.m_data, bus.m_rw}, prev_fields);
        if (bus.done0 | bus.done1) begin
            check("sb_nonempty", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_owner", bus.done1,  e.owner);
                check("sb_addr",  bus.m_addr, e.addr);
                check("sb_data",  bus.m_data, e.data);
                check("sb_rw",    bus.m_rw,   e.rw);
                check("sb_err",   bus.err,    e.err);
            end
        end
        prev_gnt    = bus.gnt0 | bus.gnt1;
        prev_fields = {bus.m_addr, bus.m_data, bus.m_rw};
    end

    task automatic push_exp(input logic owner, input logic [2:0] addr, input logic [7:0] data,
                            input logic rw, input logic err);
        exp_t e;
        e.owner = owner;
        e.addr  = addr;
        e.data  = data;
        e.rw    = rw;
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic wait_start(output int ts);
        int n = 0;
        @(negedge clk);
        while (!bus.m_start && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", bus.m_start, 1'b1);
        ts = cyc;
    endtask

    task automatic wait_done(output int td, input int bound);
        int n = 0;
        @(negedge clk);
        while (!(bus.done0 | bus.done1) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", bus.done0 | bus.done1, 1'b1);
        td = cyc;
    endtask

    // Called in the m_start cycle: busy rises two cycles after m_start and stays high for k
    // cycles; k == 0 leaves it stuck high.
    task automatic busy_seq(input int k);
        @(posedge clk);
        @(negedge clk);
        check("start_one_cycle", bus.m_start, 1'b0);
        @(posedge clk);
        #1 bus.m_busy = 1'b1;
        if (k > 0) begin
            repeat (k) @(posedge clk);
            #1 bus.m_busy = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   {bus.gnt1, bus.gnt0},   2'b00);
        check({tag, "_done"},  {bus.done1, bus.done0}, 2'b00);
        check({tag, "_err"},   bus.err,     1'b0);
        check({tag, "_start"}, bus.m_start, 1'b0);
        check({tag, "_addr"},  bus.m_addr,  3'd0);
        check({tag, "_data"},  bus.m_data,  8'd0);
        check({tag, "_rw"},    bus.m_rw,    1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ts;
        int td;

        bus.req0   = 1'b0;
        bus.req1   = 1'b0;
        bus.addr0  = 3'd0;
        bus.addr1  = 3'd0;
        bus.data0  = 8'd0;
        bus.data1  = 8'd0;
        bus.rw0    = 1'b0;
        bus.rw1    = 1'b0;
        bus.m_busy = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        @(posedge clk);
        #1 reset = 1'b1;

        // Single transaction; requester inputs change and req drops after grant
        bus.req0  = 1'b1;
        bus.addr0 = 3'h5;
        bus.data0 = 8'hA5;
        bus.rw0   = 1'b0;
        push_exp(1'b0, 3'h5, 8'hA5, 1'b0, 1'b0);
        wait_start(ts);
        check("t1_gnt0", bus.gnt0,   1'b1);
        check("t1_gnt1", bus.gnt1,   1'b0);
        check("t1_addr", bus.m_addr, 3'h5);
        check("t1_data", bus.m_data, 8'hA5);
        check("t1_rw",   bus.m_rw,   1'b0);
        bus.data0 = 8'h3C;
        bus.req0  = 1'b0;
        busy_seq(10);
        wait_done(td, 64);
        check("t1_latency",   td - ts,    13);
        check("t1_done0",     bus.done0,  1'b1);
        check("t1_data_held", bus.m_data, 8'hA5);
        @(negedge clk);
        check("t1_gnt_drop", bus.gnt0, 1'b0);

        // No response from master: busy-wait timeout
        bus.req1  = 1'b1;
        bus.addr1 = 3'h2;
        bus.data1 = 8'h5A;
        bus.rw1   = 1'b1;
        push_exp(1'b1, 3'h2, 8'h5A, 1'b1, 1'b1);
        wait_start(ts);
        check("t2_gnt1", bus.gnt1, 1'b1);
        bus.req1 = 1'b0;
        wait_done(td, 64);
        check("t2_latency", td - ts, BW + 1);
        check("t2_err",     bus.err, 1'b1);

        // m_busy high while idle must not start anything
        @(posedge clk);
        #1 bus.m_busy = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t2_idle_busy", bus.m_start | bus.gnt0 | bus.gnt1, 1'b0);
        end
        @(posedge clk);
        #1 bus.m_busy = 1'b0;

        // Same requester retried, serviced normally
        bus.req1 = 1'b1;
        push_exp(1'b1, 3'h2, 8'h5A, 1'b1, 1'b0);
        wait_start(ts);
        bus.req1 = 1'b0;
        busy_seq(3);
        wait_done(td, 64);
        check("t2_retry_latency", td - ts, 6);
        check("t2_retry_err",     bus.err, 1'b0);

        // Master hangs busy: transaction timeout at saturated count
        bus.req0  = 1'b1;
        bus.addr0 = 3'h6;
        bus.data0 = 8'hC3;
        bus.rw0   = 1'b1;
        push_exp(1'b0, 3'h6, 8'hC3, 1'b1, 1'b1);
        wait_start(ts);
        bus.req0 = 1'b0;
        busy_seq(0);
        wait_done(td, TO + 32);
        check("t3_latency", td - ts,    TO + 3);
        check("t3_addr",    bus.m_addr, 3'h6);
        check("t3_err",     bus.err,    1'b1);
        @(posedge clk);
        #1 bus.m_busy = 1'b0;

        // Tie held from reset release: strict alternation 0,1,0,1
        reset     = 1'b0;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        bus.addr0 = 3'h1;
        bus.data0 = 8'h11;
        bus.rw0   = 1'b0;
        bus.addr1 = 3'h7;
        bus.data1 = 8'h77;
        bus.rw1   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push_exp(1'b0, 3'h1, 8'h11, 1'b0, 1'b0);
            else            push_exp(1'b1, 3'h7, 8'h77, 1'b1, 1'b0);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_start(ts);
            check("t4_gnt0", bus.gnt0,   i % 2 == 0);
            check("t4_gnt1", bus.gnt1,   i % 2 == 1);
            check("t4_addr", bus.m_addr, (i % 2 == 0) ? 3'h1 : 3'h7);
            if (i == 3) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            busy_seq(5);
            wait_done(td, 64);
            check("t4_latency", td - ts, 8);
        end

        // Reset during WAIT_IDLE abandons the transaction without a done pulse
        bus.req0  = 1'b1;
        bus.addr0 = 3'h4;
        bus.data0 = 8'h44;
        bus.rw0   = 1'b0;
        wait_start(ts);
        bus.req0 = 1'b0;
        busy_seq(0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("t5_rst");
        bus.m_busy = 1'b0;
        push_exp(1'b0, 3'h4, 8'h44, 1'b0, 1'b0);
        push_exp(1'b1, 3'h7, 8'h77, 1'b1, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        wait_start(ts);
        check("t5_first_gnt0", bus.gnt0, 1'b1);
        bus.req0 = 1'b0;
        busy_seq(2);
        wait_done(td, 64);
        wait_start(ts);
        check("t5_second_gnt1", bus.gnt1, 1'b1);
        bus.req1 = 1'b0;
        busy_seq(2);
        wait_done(td, 64);
        check("t5_latency", td - ts, 5);

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
